// File: rtl/scic_io_pkg.sv
// rtl/scic_io_pkg.sv - shared widths and debounce lengths for the SCIC board I/O
package scic_io_pkg;

    localparam int SWITCH_WIDTH          = 4;
    localparam int LED_WIDTH             = 4;
    localparam int DEBOUNCE_CYCLES_SIM   = 4;
    localparam int DEBOUNCE_CYCLES_BOARD = 1_000_000;

    // Counter must hold 0..cycles-1; a single-cycle debounce still needs one bit.
    function automatic int counter_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchronizer plus run-length debounce for one switch bit
module debounce_bit
    import scic_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic update
);

    localparam int              CW   = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // High on the edge where stable takes the new value; decoded from registers only.
    assign update = (sync2 != stable) && (cnt == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (update) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - per-bit debounce of raw slide switches with change pulse and pending flag
module switch_conditioner
    import scic_io_pkg::*;
#(
    parameter int WIDTH           = SWITCH_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] switches_raw,
    input  logic             switch_ack,
    output logic [WIDTH-1:0] switches,
    output logic             changed,
    output logic             pending
);

    logic [WIDTH-1:0] update_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clock  (clock),
            .reset  (reset),
            .raw    (switches_raw[i]),
            .stable (switches[i]),
            .update (update_bits[i])
        );
    end

    // A new value beats a simultaneous ack so the core never misses it.
    always_ff @(posedge clock) begin
        if (reset) begin
            changed <= 1'b0;
            pending <= 1'b0;
        end else begin
            changed <= |update_bits;
            if (|update_bits) begin
                pending <= 1'b1;
            end else if (switch_ack) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// tb/tb_switch_conditioner.sv - directed vector table plus randomized run against a window-based model
module tb_switch_conditioner;

    localparam int W = 4;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] switches_raw = '0;
    logic         switch_ack = 1'b0;
    logic [W-1:0] switches;
    logic         changed;
    logic         pending;

    switch_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clock        (clock),
        .reset        (reset),
        .switches_raw (switches_raw),
        .switch_ack   (switch_ack),
        .switches     (switches),
        .changed      (changed),
        .pending      (pending)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         rst;
        logic [W-1:0] raw;
        logic         ack;
        logic [W-1:0] sw;
        logic         ch;
        logic         p;
    } vec_t;

    vec_t vecs[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Model: m_cap[0] is the newest capture; a bit flips once the D captures
    // that have cleared the synchronizer all disagree with the stable value.
    logic [W-1:0] m_cap [0:D];
    logic [W-1:0] m_stable;
    logic         m_changed;
    logic         m_pending;

    task automatic model_edge(input logic r, input logic [W-1:0] w, input logic a);
        logic [W-1:0] mask;
        logic         all_diff;
        if (r) begin
            for (int j = 0; j <= D; j++) m_cap[j] = '0;
            m_stable  = '0;
            m_changed = 1'b0;
            m_pending = 1'b0;
        end else begin
            mask = '0;
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= D; j++)
                    if (m_cap[j][i] == m_stable[i]) all_diff = 1'b0;
                mask[i] = all_diff;
            end
            m_stable  = m_stable ^ mask;
            m_changed = |mask;
            if (|mask)  m_pending = 1'b1;
            else if (a) m_pending = 1'b0;
            for (int j = D; j >= 1; j--) m_cap[j] = m_cap[j-1];
            m_cap[0] = w;
        end
    endtask

    task automatic add(input logic rst, input logic [W-1:0] raw, input logic ack,
                       input logic [W-1:0] sw, input logic ch, input logic p, input int n);
        vec_t v;
        v.rst = rst; v.raw = raw; v.ack = ack; v.sw = sw; v.ch = ch; v.p = p;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic apply(input logic r, input logic [W-1:0] w, input logic a);
        @(negedge clock);
        reset        = r;
        switches_raw = w;
        switch_ack   = a;
        @(posedge clock);
        model_edge(r, w, a);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [W-1:0] esw, input logic ech, input logic ep);
        vectors++;
        if (switches !== esw || changed !== ech || pending !== ep) begin
            miscompares++;
            $display("FAIL %s #%0d: got sw=%b changed=%b pending=%b, want sw=%b changed=%b pending=%b",
                     name, idx, switches, changed, pending, esw, ech, ep);
        end
    endtask

    initial begin
        // reset held with switches on, then first accept 5 edges after release
        add(1, 4'b1111, 0, 4'b0000, 0, 0, 3);
        add(0, 4'b1111, 0, 4'b0000, 0, 0, 5);
        add(0, 4'b1111, 0, 4'b1111, 1, 1, 1);
        add(0, 4'b1111, 0, 4'b1111, 0, 1, 2);
        // clean change 0000 -> 0101
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 2);
        add(0, 4'b0101, 0, 4'b0000, 0, 0, 5);
        add(0, 4'b0101, 0, 4'b0101, 1, 1, 1);
        add(0, 4'b0101, 0, 4'b0101, 0, 1, 3);
        // ack clears pending; ack with nothing pending does nothing
        add(0, 4'b0101, 1, 4'b0101, 0, 0, 1);
        add(0, 4'b0101, 0, 4'b0101, 0, 0, 2);
        add(0, 4'b0101, 1, 4'b0101, 0, 0, 1);
        // glitch of 3 rejected, pulse of 4 accepted and later released
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b0100, 0, 4'b0000, 0, 0, 3);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 8);
        add(0, 4'b0100, 0, 4'b0000, 0, 0, 4);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b0000, 0, 4'b0100, 1, 1, 1);
        add(0, 4'b0000, 0, 4'b0100, 0, 1, 3);
        add(0, 4'b0000, 0, 4'b0000, 1, 1, 1);
        // ack, then update coinciding with ack keeps pending set
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 1);
        add(0, 4'b1000, 0, 4'b0000, 0, 0, 5);
        add(0, 4'b1000, 1, 4'b1000, 1, 1, 1);
        add(0, 4'b1000, 0, 4'b1000, 0, 1, 1);
        // bit 0 then bit 3 one edge later: two pulses
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b0001, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b1001, 0, 4'b0000, 0, 0, 4);
        add(0, 4'b1001, 0, 4'b0001, 1, 1, 1);
        add(0, 4'b1001, 0, 4'b1001, 1, 1, 1);
        add(0, 4'b1001, 0, 4'b1001, 0, 1, 1);
        // bits 0 and 3 together: one pulse
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b1001, 0, 4'b0000, 0, 0, 5);
        add(0, 4'b1001, 0, 4'b1001, 1, 1, 1);
        add(0, 4'b1001, 0, 4'b1001, 0, 1, 1);
        // reset mid-debounce discards the partial count
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b0011, 0, 4'b0000, 0, 0, 3);
        add(1, 4'b0011, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b0011, 0, 4'b0000, 0, 0, 5);
        add(0, 4'b0011, 0, 4'b0011, 1, 1, 1);
        add(0, 4'b0011, 0, 4'b0011, 0, 1, 1);

        foreach (vecs[k]) begin
            apply(vecs[k].rst, vecs[k].raw, vecs[k].ack);
            check("directed", k, vecs[k].sw, vecs[k].ch, vecs[k].p);
        end

        begin
            logic [W-1:0] raw_val;
            logic         rst_val;
            int           hold;
            raw_val = '0;
            hold    = 0;
            for (int c = 0; c < 1500; c++) begin
                if (hold == 0) begin
                    if ($urandom_range(0, 2) == 0)
                        raw_val = raw_val ^ (W'(1) << $urandom_range(0, W-1));
                    else
                        raw_val = W'($urandom);
                    hold = $urandom_range(1, 2*D + 2);
                end
                hold--;
                rst_val = (c < 2) || ($urandom_range(0, 199) == 0);
                apply(rst_val, raw_val, ($urandom_range(0, 7) == 0));
                check("random", c, m_stable, m_changed, m_pending);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
